con_ff_unit: RTL and testbench
==============================

# con_ff_unit

Parametrised conditional-branch flip-flop unit for the datapath's branch logic. It samples the 4-bit condition field of the instruction register and the bus value when `ConIn` is asserted, and registers the branch decision on `Con`. It adds width/field parametrisation, an optional pipeline stage, extended conditions, a valid/read handshake, sticky error flags and saturating evaluation/taken counters. It sits between the bus/IR and the control unit's PC-load decision.

## Interface
- `DATA_W`, 32: bus width; bit `DATA_W-1` is the sign bit.
- `IR_W`, 32: instruction register width.
- `CC_LSB`, 19: LSB of the 4-bit condition field, `IR[CC_LSB+3:CC_LSB]`; `CC_LSB+3 < IR_W` is required.
- `PIPE`, 0: 0 gives a single-cycle evaluation; 1 adds a registered flag stage.
- `CNT_W`, 16: counter width.

Ports:
- `clock`, in, 1: the only clock; rising edge.
- `clear`, in, 1: asynchronous, active-low reset.
- `ConIn`, in, 1: evaluate strobe.
- `read`, in, 1: consumer acknowledges the held result.
- `IR`, in, `IR_W`: instruction register.
- `BusMuxOut`, in, `DATA_W`: operand from the bus.
- `Con`, out, 1: registered branch decision.
- `con_valid`, out, 1: `Con` holds an unread result.
- `con_busy`, out, 1: evaluation in flight (`PIPE=1` only).
- `illegal_cc`, out, 1: sticky; an undefined condition code was evaluated.
- `overrun`, out, 1: sticky; `ConIn` arrived while busy.
- `eval_count`, out, `CNT_W`: completed evaluations, saturating.
- `taken_count`, out, `CNT_W`: completed evaluations with `Con=1`, saturating.

## Operation
- Flags are computed from `BusMuxOut` at the `ConIn` edge:
  - `Z = ~|BusMuxOut`, the reduction NOR of all `DATA_W` bits.
  - `N = BusMuxOut[DATA_W-1]`.
- Condition codes:
  - 0000: `Z`.
  - 0001: `~Z`.
  - 0010: `~N` (>= 0).
  - 0011: `N` (< 0).
  - 0100: `~Z & ~N` (> 0).
  - 0101: `Z | N` (<= 0).
  - 0110: 1 (always).
  - 0111: 0 (never).
  - 1000–1111: result 0 and `illegal_cc` set.
- The condition code and flags are captured on the same edge. Later changes to `IR` or `BusMuxOut` do not affect an in-flight or held result.
- States: IDLE, EVAL (exists only when `PIPE=1`), HOLD.
- IDLE:
  - `ConIn=1` with `PIPE=0`: `Con` is written and the state goes to HOLD.
  - `ConIn=1` with `PIPE=1`: code, `Z` and `N` are latched and the state goes to EVAL.
- EVAL:
  - `con_busy=1`.
  - The next edge writes `Con` and the state goes to HOLD.
  - `ConIn` in EVAL is ignored and sets `overrun`.
  - `read` in EVAL is ignored.
- HOLD:
  - `con_valid=1`.
  - `read=1` alone: state goes to IDLE and `con_valid` falls; `Con` keeps its value.
  - `ConIn=1`, with or without `read`: a new evaluation starts exactly as from IDLE; the old result is discarded without setting `overrun`. With `PIPE=1`, `con_valid=0` during the resulting EVAL.
- Counters advance only on the edge that writes `Con`:
  - `eval_count` increments by 1.
  - `taken_count` increments by 1 when the new `Con=1`.
  - Both hold at all-ones.
  - Illegal-code evaluations count as evaluations (not taken).

## Timing
- `clear` low, asynchronously:
  - `Con`, `con_valid`, `con_busy`, `illegal_cc`, `overrun` go to 0.
  - Both counters go to 0.
  - State goes to IDLE.
- Reset mid-EVAL aborts the evaluation; no counter changes.
- Release is synchronous to the first `clock` edge with `clear` high.
- `PIPE=0`: with `ConIn` sampled at edge k, `Con` and `con_valid=1` are visible after edge k (latency 1).
- `PIPE=1`:
  - `con_busy=1` after edge k.
  - `Con` and `con_valid=1` after edge k+1 (latency 2).
  - `con_busy=0` after edge k+1.
- Throughput:
  - `PIPE=0`: one evaluation per cycle.
  - `PIPE=1`: one evaluation per 2 cycles; back-to-back `ConIn` raises `overrun`.
- `illegal_cc` and `overrun` clear only on reset.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset:** `clear` low mid-cycle -> all outputs 0 immediately. With `PIPE=1`, asserting `clear` during EVAL -> `eval_count` unchanged and state IDLE.
- **Code sweep, `PIPE=0`:** codes 0–7 applied with `BusMuxOut` = 0, 5, 0xFFFFFFFF. Expected `Con` for 0/5/0xFFFFFFFF:
  - code 0: 1/0/0
  - code 1: 0/1/1
  - code 2: 1/1/0
  - code 3: 0/0/1
  - code 4: 0/1/0
  - code 5: 1/0/1
  - code 6: 1/1/1
  - code 7: 0/0/0
  - `BusMuxOut=0x00000001` with code 0 -> `Con=0`.
- **Illegal code:** code 1010 -> `Con=0`, `illegal_cc=1` held across later legal evaluations, `eval_count` +1.
- **Handshake:** `ConIn` then `read` 3 cycles later -> `con_valid` high for exactly 3 cycles and `Con` unchanged after the read. `ConIn` and `read` in the same HOLD cycle -> new result, `con_valid` stays 1 (`PIPE=0`).
- **`PIPE=1`:** `ConIn` on 2 consecutive edges -> second strobe ignored, `overrun=1`, `Con` reflects the first operand after 2 edges.
- **Saturation:** `CNT_W=3`, 9 evaluations with code 0110 -> `eval_count=7`, `taken_count=7`.

Source files
------------

// File: rtl/con_ff_unit.sv
// con_ff_unit: conditional-branch flip-flop with optional pipeline, handshake, sticky errors and counters
module con_ff_unit #(
    parameter int DATA_W = 32,
    parameter int IR_W   = 32,
    parameter int CC_LSB = 19,
    parameter int PIPE   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              ConIn,
    input  logic              read,
    input  logic [IR_W-1:0]   IR,
    input  logic [DATA_W-1:0] BusMuxOut,
    output logic              Con,
    output logic              con_valid,
    output logic              con_busy,
    output logic              illegal_cc,
    output logic              overrun,
    output logic [CNT_W-1:0]  eval_count,
    output logic [CNT_W-1:0]  taken_count
);
    typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

    state_t             state_q, state_d;
    logic               con_q, con_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               illegal_q, illegal_d;
    logic               overrun_q, overrun_d;
    logic [CNT_W-1:0]   eval_q, eval_d;
    logic [CNT_W-1:0]   taken_q, taken_d;
    logic [3:0]         cc_q, cc_d;
    logic               z_q, z_d;
    logic               n_q, n_d;
    logic [3:0]         live_cc, cc_sel;
    logic               live_z, live_n, z_sel, n_sel, res, wr;
    logic [7:0]         tbl;
    logic               unused_ir;

    assign unused_ir = ^IR;

    // next-state: evaluate from live inputs (PIPE=0) or from the latched snapshot in EVAL
    always_comb begin
        live_cc   = IR[CC_LSB +: 4];
        live_z    = ~|BusMuxOut;
        live_n    = BusMuxOut[DATA_W-1];
        cc_sel    = (state_q == EVAL) ? cc_q : live_cc;
        z_sel     = (state_q == EVAL) ? z_q  : live_z;
        n_sel     = (state_q == EVAL) ? n_q  : live_n;
        tbl       = {1'b0, 1'b1, z_sel | n_sel, ~z_sel & ~n_sel, n_sel, ~n_sel, ~z_sel, z_sel};
        res       = ~cc_sel[3] & tbl[cc_sel[2:0]];
        wr        = 1'b0;
        state_d   = state_q;
        con_d     = con_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        illegal_d = illegal_q;
        overrun_d = overrun_q;
        eval_d    = eval_q;
        taken_d   = taken_q;
        cc_d      = cc_q;
        z_d       = z_q;
        n_d       = n_q;
        if (state_q == EVAL) begin
            wr        = 1'b1;
            state_d   = HOLD;
            busy_d    = 1'b0;
            valid_d   = 1'b1;
            overrun_d = overrun_q | ConIn;
        end else if (ConIn) begin
            if (PIPE != 0) begin
                state_d = EVAL;
                busy_d  = 1'b1;
                valid_d = 1'b0;
                cc_d    = live_cc;
                z_d     = live_z;
                n_d     = live_n;
            end else begin
                wr      = 1'b1;
                state_d = HOLD;
                valid_d = 1'b1;
            end
        end else if (state_q == HOLD && read) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
        if (wr) begin
            con_d     = res;
            illegal_d = illegal_q | cc_sel[3];
            eval_d    = eval_q + CNT_W'(eval_q != '1);
            taken_d   = taken_q + CNT_W'(res && taken_q != '1);
        end
    end

    // all state and outputs registered; clear aborts any evaluation in flight
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= IDLE;
            con_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            illegal_q <= 1'b0;
            overrun_q <= 1'b0;
            eval_q    <= '0;
            taken_q   <= '0;
            cc_q      <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            con_q     <= con_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            illegal_q <= illegal_d;
            overrun_q <= overrun_d;
            eval_q    <= eval_d;
            taken_q   <= taken_d;
            cc_q      <= cc_d;
            z_q       <= z_d;
            n_q       <= n_d;
        end
    end

    assign Con         = con_q;
    assign con_valid   = valid_q;
    assign con_busy    = busy_q;
    assign illegal_cc  = illegal_q;
    assign overrun     = overrun_q;
    assign eval_count  = eval_q;
    assign taken_count = taken_q;
endmodule

// File: tb/tb_con_ff_unit.sv
// tb_con_ff_unit: directed checks of con_ff_unit in single-cycle, pipelined and narrow-counter builds
module tb_con_ff_unit;
    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    logic        c0, r0, c1, r1, c2, r2;
    logic [31:0] ir0, b0, ir1, b1, ir2, b2;
    logic        con0, val0, busy0, ill0, ovr0;
    logic        con1, val1, busy1, ill1, ovr1;
    logic        con2, val2, busy2, ill2, ovr2;
    logic [15:0] ev0, tk0, ev1, tk1;
    logic [2:0]  ev2, tk2;

    con_ff_unit #(.PIPE(0)) u0 (
        .clock(clk), .clear(clear), .ConIn(c0), .read(r0), .IR(ir0), .BusMuxOut(b0),
        .Con(con0), .con_valid(val0), .con_busy(busy0), .illegal_cc(ill0), .overrun(ovr0),
        .eval_count(ev0), .taken_count(tk0)
    );
    con_ff_unit #(.PIPE(1)) u1 (
        .clock(clk), .clear(clear), .ConIn(c1), .read(r1), .IR(ir1), .BusMuxOut(b1),
        .Con(con1), .con_valid(val1), .con_busy(busy1), .illegal_cc(ill1), .overrun(ovr1),
        .eval_count(ev1), .taken_count(tk1)
    );
    con_ff_unit #(.PIPE(0), .CNT_W(3)) u2 (
        .clock(clk), .clear(clear), .ConIn(c2), .read(r2), .IR(ir2), .BusMuxOut(b2),
        .Con(con2), .con_valid(val2), .con_busy(busy2), .illegal_cc(ill2), .overrun(ovr2),
        .eval_count(ev2), .taken_count(tk2)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0]  tab [8] = '{3'b100, 3'b011, 3'b110, 3'b001, 3'b010, 3'b101, 3'b111, 3'b000};
    logic [31:0] bus_v [3] = '{32'h0, 32'h5, 32'hFFFF_FFFF};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [3:0] cc);
        return (32'hA5A5_A5A5 & ~(32'hF << 19)) | (32'(cc) << 19);
    endfunction

    initial begin
        {c0, r0, c1, r1, c2, r2} = '0;
        {ir0, b0, ir1, b1, ir2, b2} = '0;
        clear = 1'b1;
        #2 clear = 1'b0;
        #1;
        chk("rst con", con0, 0);
        chk("rst valid", val0, 0);
        chk("rst busy", busy1, 0);
        chk("rst ill", ill0, 0);
        chk("rst ovr", ovr1, 0);
        chk("rst ev", ev0, 0);
        chk("rst tk", tk0, 0);
        @(posedge clk);
        #1 clear = 1'b1;
        step();

        // single-cycle code sweep
        c0 = 1'b1;
        for (int code = 0; code < 8; code++) begin
            for (int j = 0; j < 3; j++) begin
                ir0 = mk_ir(4'(code));
                b0  = bus_v[j];
                step();
                chk($sformatf("sweep c%0d b%0d", code, j), con0, 32'(tab[code][2-j]));
            end
        end
        chk("sweep valid", val0, 1);
        chk("sweep busy", busy0, 0);
        chk("sweep ev", ev0, 24);
        chk("sweep tk", tk0, 12);
        ir0 = mk_ir(0);
        b0  = 32'h1;
        step();
        chk("z lsb", con0, 0);
        chk("ill before", ill0, 0);

        // illegal code, then a legal one keeps the sticky flag
        ir0 = mk_ir(4'b1010);
        b0  = 32'h0;
        step();
        chk("ill con", con0, 0);
        chk("ill flag", ill0, 1);
        chk("ill ev", ev0, 26);
        chk("ill tk", tk0, 12);
        ir0 = mk_ir(6);
        step();
        chk("ill2 con", con0, 1);
        chk("ill2 flag", ill0, 1);
        chk("ill2 ev", ev0, 27);
        chk("ill2 tk", tk0, 13);

        // handshake: read three cycles after the strobe
        ir0 = mk_ir(3);
        b0  = 32'h8000_0000;
        step();
        c0  = 1'b0;
        ir0 = mk_ir(7);
        b0  = 32'h0;
        chk("hs con", con0, 1);
        chk("hs v0", val0, 1);
        step();
        chk("hs v1", val0, 1);
        step();
        chk("hs v2", val0, 1);
        r0 = 1'b1;
        step();
        r0 = 1'b0;
        chk("hs v3", val0, 0);
        chk("hs con kept", con0, 1);
        step();
        chk("hs idle con", con0, 1);
        chk("hs idle valid", val0, 0);
        c0 = 1'b1;
        step();
        chk("hs c7", con0, 0);
        r0  = 1'b1;
        ir0 = mk_ir(6);
        step();
        c0 = 1'b0;
        r0 = 1'b0;
        chk("hs rd+con con", con0, 1);
        chk("hs rd+con valid", val0, 1);
        chk("hs ev", ev0, 30);
        chk("hs tk", tk0, 15);
        chk("p0 ovr", ovr0, 0);

        // pipelined: back-to-back strobes
        c1  = 1'b1;
        ir1 = mk_ir(0);
        b1  = 32'h0;
        step();
        b1 = 32'h5;
        chk("p1 busy", busy1, 1);
        chk("p1 valid", val1, 0);
        chk("p1 con", con1, 0);
        chk("p1 ovr0", ovr1, 0);
        step();
        c1 = 1'b0;
        chk("p1 con2", con1, 1);
        chk("p1 valid2", val1, 1);
        chk("p1 busy2", busy1, 0);
        chk("p1 ovr", ovr1, 1);
        chk("p1 ev", ev1, 1);
        chk("p1 tk", tk1, 1);
        step();
        chk("p1 hold con", con1, 1);
        chk("p1 hold valid", val1, 1);

        // new evaluation from HOLD; inputs change while in flight
        c1  = 1'b1;
        ir1 = mk_ir(3);
        b1  = 32'h5;
        step();
        c1  = 1'b0;
        ir1 = mk_ir(6);
        b1  = 32'h8000_0000;
        chk("p1 re valid", val1, 0);
        chk("p1 re busy", busy1, 1);
        chk("p1 re old con", con1, 1);
        step();
        chk("p1 re con", con1, 0);
        chk("p1 re valid2", val1, 1);
        chk("p1 re ev", ev1, 2);
        chk("p1 re tk", tk1, 1);

        // asynchronous clear in the middle of an evaluation
        c1 = 1'b1;
        step();
        c1 = 1'b0;
        chk("p1 abort busy", busy1, 1);
        #2 clear = 1'b0;
        #1;
        chk("mid con0", con0, 0);
        chk("mid valid0", val0, 0);
        chk("mid ill0", ill0, 0);
        chk("mid ev0", ev0, 0);
        chk("mid busy1", busy1, 0);
        chk("mid ovr1", ovr1, 0);
        chk("mid tk1", tk1, 0);
        step();
        clear = 1'b1;
        step();
        step();
        chk("abort con", con1, 0);
        chk("abort valid", val1, 0);
        chk("abort busy", busy1, 0);
        chk("abort ev", ev1, 0);

        // narrow counters saturate
        c2  = 1'b1;
        ir2 = mk_ir(6);
        repeat (9) step();
        c2 = 1'b0;
        chk("sat ev", ev2, 7);
        chk("sat tk", tk2, 7);
        chk("sat con", con2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
